qcldpc_parity_accumulator: RTL

//  Downstream of the encoder controller's circular-shifter bank. Consumes one rotated

---
 rtl/qcldpc_parity_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/qcldpc_parity_accumulator.sv
// Accumulates rotated info blocks into one lambda vector per parity row. A finished set
// passes through a one-cycle completion stage into a single output buffer with valid/ready.
module qcldpc_parity_accumulator #(
  parameter int HIGHEST_SUPPORTED_Z_VAL      = 81,
  parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4,
  parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int LEVEL_OF_PARALLELIZATION     = 1,
  localparam int MZ    = HIGHEST_SUPPORTED_Z_VAL,
  localparam int NP    = NUM_PARITY_BLKS_PER_CODE_BLK,
  localparam int IB    = NUM_INFO_BLKS_PER_CODE_BLK,
  localparam int PL    = LEVEL_OF_PARALLELIZATION,
  localparam int CW    = $clog2(IB + 1)
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic [NP*PL*(MZ+1)-1:0]  rot_in,
  input  logic [MZ-1:0]            z_mask,
  input  logic                     clr,
  output logic [NP*MZ-1:0]         lam_data,
  output logic                     lam_valid,
  input  logic                     lam_ready,
  output logic [CW-1:0]            col_cnt,
  output logic                     err_lane,
  output logic                     err_ovf
);

  localparam int LANES = NP * PL;
  localparam int LW    = MZ + 1;

  if (IB % PL != 0) begin : g_bad_cfg
    $fatal(1, "NUM_INFO_BLKS_PER_CODE_BLK must be a multiple of LEVEL_OF_PARALLELIZATION");
  end

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  logic [LANES-1:0]        lane_vld;
  logic [NP-1:0][MZ-1:0]   beat_xor;
  logic [NP-1:0][MZ-1:0]   acc_q;
  logic [NP-1:0][MZ-1:0]   acc_nxt;
  logic [NP-1:0][MZ-1:0]   pend_data;
  logic [NP-1:0][MZ-1:0]   buf_data;
  logic                    pend_vld;
  logic [CW-1:0]           col_q;
  logic                    beat;
  logic                    partial;
  logic                    last_beat;
  logic                    load;
  logic                    ovf;
  buf_state_t              buf_state;
  buf_state_t              buf_next;

  // Fold the PL columns of each parity row into one masked contribution.
  always_comb begin
    lane_vld = '0;
    beat_xor = '0;
    acc_nxt  = acc_q;
    for (int n = 0; n < LANES; n++) begin
      lane_vld[n] = rot_in[n*LW + MZ];
    end
    for (int r = 0; r < NP; r++) begin
      for (int p = 0; p < PL; p++) begin
        beat_xor[r] = beat_xor[r] ^ rot_in[(r*PL + p)*LW +: MZ];
      end
      acc_nxt[r] = acc_q[r] ^ (beat_xor[r] & z_mask);
    end
  end

  assign beat      = (&lane_vld) && !clr;
  assign partial   = (|lane_vld) && !(&lane_vld) && !clr;
  assign last_beat = beat && (col_q == CW'(IB - PL));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      col_q    <= '0;
      err_lane <= 1'b0;
    end else begin
      if (clr || last_beat) begin
        acc_q <= '0;
        col_q <= '0;
      end else if (beat) begin
        acc_q <= acc_nxt;
        col_q <= col_q + CW'(PL);
      end
      if (partial) begin
        err_lane <= 1'b1;
      end
    end
  end

  // Completion stage: holds a finished set for one cycle so acc can restart immediately.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      pend_vld <= last_beat;
      if (last_beat) begin
        pend_data <= acc_nxt;
      end
    end
  end

  assign load = pend_vld && ((buf_state == BUF_EMPTY) || lam_ready);
  assign ovf  = pend_vld && (buf_state == BUF_FULL) && !lam_ready;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_next;
    end
  end

  always_comb begin
    buf_next = buf_state;
    case (buf_state)
      BUF_EMPTY: if (pend_vld) buf_next = BUF_FULL;
      BUF_FULL:  if (lam_ready && !pend_vld) buf_next = BUF_EMPTY;
      default:   buf_next = BUF_EMPTY;
    endcase
  end

  always_comb begin
    lam_valid = (buf_state == BUF_FULL);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (load) begin
        buf_data <= pend_data;
      end
      if (ovf) begin
        err_ovf <= 1'b1;
      end
    end
  end

  assign lam_data = buf_data;
  assign col_cnt  = col_q;

endmodule
